gdsp_ctrl: RTL and testbench
============================

GDSP_CTRL -- requirements
Module: gdsp_ctrl

Interface
REQ-001 Parameter SPS, default 4: clocks per symbol, legal range 2..16.
REQ-002 Parameter DEBOUNCE_CYC, default 270000: stable-sample count that accepts a new button level (~10 ms at 27 MHz).
REQ-003 Parameter NUM_LVLS, default 4: number of noise levels, legal range 2..8.
REQ-004 Parameters NOISE_BASE, default 32, and NOISE_STEP, default 32: level k magnitude = NOISE_BASE + k*NOISE_STEP.
REQ-005 Parameter DRAIN_CYC, default 64: pipeline flush cycles after the last symbol.
REQ-006 Parameter HB_W, default 25: heartbeat counter width.
REQ-007 clk  in  1  system clock.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 btn_n  in  1  raw user button, asynchronous, active-low.
REQ-010 mode_burst  in  1  1 = burst mode, 0 = continuous mode.
REQ-011 start  in  1  one-cycle start request.
REQ-012 stop  in  1  one-cycle stop request.
REQ-013 burst_syms  in  16  symbols per burst.
REQ-014 sym_tick  out  1  one-cycle symbol strobe.
REQ-015 tx_en  out  1  datapath enable, high in RUN and DRAIN.
REQ-016 noise_mag  out  8  channel noise magnitude.
REQ-017 noise_idx  out  3  current noise level index.
REQ-018 btn_press  out  1  one-cycle debounced press pulse.
REQ-019 burst_done  out  1  one-cycle end-of-activity pulse.
REQ-020 heartbeat  out  1  MSB of the free-running counter.

Function
REQ-021 btn_n passes through a 2-FF synchroniser preset to 1, then the debouncer.
REQ-022 Debounce: the accepted level changes only after DEBOUNCE_CYC consecutive synchronised samples differ from it; any equal sample clears the counter.
REQ-023 btn_press pulses one cycle on the accepted 1->0 transition; release produces no pulse.
REQ-024 On btn_press, noise_idx increments; NUM_LVLS-1 wraps to 0.
REQ-025 noise_mag is registered from noise_idx per REQ-004, saturates at 255, and follows noise_idx with 1 cycle latency.
REQ-026 FSM states are IDLE, RUN, DRAIN, DONE.
REQ-027 IDLE->RUN when start=1, stop=0 and (mode_burst=0 or burst_syms!=0); mode_burst is latched on this transition.
REQ-028 In IDLE, start with mode_burst=1 and burst_syms=0 is ignored and produces no burst_done.
REQ-029 start and stop asserted in the same IDLE cycle: stop wins and the FSM stays in IDLE.
REQ-030 On entry to RUN, the SPS counter clears to 0; sym_tick = (state==RUN && cnt==0); cnt wraps SPS-1->0; the first tick occurs in the first RUN cycle.
REQ-031 Burst RUN: ticks are counted, and the FSM goes to DRAIN in the cycle after the burst_syms-th tick.
REQ-032 Continuous RUN: runs until stop.
REQ-033 Any RUN: stop goes to DRAIN next cycle, and a tick in the same cycle still counts.
REQ-034 DRAIN: tx_en=1, no ticks, lasts exactly DRAIN_CYC cycles, then goes to DONE.
REQ-035 DONE: lasts one cycle with burst_done=1, then IDLE.
REQ-036 start is ignored outside IDLE; stop is ignored in DRAIN, DONE and IDLE.
REQ-037 A mode_burst change during activity has no effect until the next IDLE->RUN.
REQ-038 heartbeat = bit HB_W-1 of a free-running HB_W-bit counter that wraps silently.

Reset
REQ-039 Reset values: state IDLE; sym_tick, tx_en, btn_press, burst_done, heartbeat = 0; noise_idx = 0; noise_mag = NOISE_BASE; synchroniser and accepted level = 1; all counters 0.
REQ-040 Reset mid-RUN or mid-DRAIN returns immediately to IDLE with no burst_done pulse.

Structure
REQ-041 The ctrl_state_t enum and the default NOISE_BASE/NOISE_STEP constants reside in gdsp_pkg.
REQ-042 The synchroniser and debouncer form sub-module btn_debounce (parameter DEBOUNCE_CYC; outputs level and press pulse).

Verification (SPS=4, DEBOUNCE_CYC=8, DRAIN_CYC=5, NUM_LVLS=4)
REQ-043 Burst: mode_burst=1, burst_syms=3, start at t0 -> ticks at t0+1, +5, +9; tx_en high t0+1..t0+15; burst_done at t0+16.
REQ-044 Button: 5-cycle low glitch -> no press; 20-cycle low -> exactly one btn_press; 4 presses -> noise_mag 64, 96, 128, then 32.
REQ-045 Continuous: mode_burst=0, start, 10 ticks, stop -> 5 DRAIN cycles, then burst_done; a mode flip mid-run changes nothing.
REQ-046 Edges: burst_syms=0 start -> stays IDLE; start with stop -> IDLE; start during DRAIN -> ignored.
REQ-047 Reset asserted during RUN -> all outputs at reset values, no burst_done; a new start then behaves as REQ-043.

Source files
------------

// File: rtl/gdsp_pkg.sv
// Shared types and constants for the gdsp control slice.
package gdsp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } ctrl_state_t;

  localparam int DEF_NOISE_BASE = 32;
  localparam int DEF_NOISE_STEP = 32;

  // Magnitude of level k, clipped to the 8-bit output range.
  function automatic logic [7:0] noise_lvl(
    input logic [2:0] k,
    input int         base,
    input int         step
  );
    int m;
    m = base + int'(k) * step;
    return (m > 255) ? 8'd255 : 8'(m);
  endfunction

endpackage

// File: rtl/gdsp_ctrl_btn_debounce.sv
// Button synchroniser and debouncer with press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 270000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          samp;

  assign samp = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn_n};
      press <= 1'b0;
      if (samp == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        level <= samp;
        cnt   <= '0;
        press <= ~samp;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gdsp_ctrl.sv
// Channel-sim controller: symbol timing, burst FSM,
// button-selected noise level and heartbeat.
module gdsp_ctrl
  import gdsp_pkg::*;
#(
  parameter int SPS          = 4,
  parameter int DEBOUNCE_CYC = 270000,
  parameter int NUM_LVLS     = 4,
  parameter int NOISE_BASE   = DEF_NOISE_BASE,
  parameter int NOISE_STEP   = DEF_NOISE_STEP,
  parameter int DRAIN_CYC    = 64,
  parameter int HB_W         = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_n,
  input  logic        mode_burst,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] burst_syms,
  output logic        sym_tick,
  output logic        tx_en,
  output logic [7:0]  noise_mag,
  output logic [2:0]  noise_idx,
  output logic        btn_press,
  output logic        burst_done,
  output logic        heartbeat
);

  localparam int SW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int DW = $clog2(DRAIN_CYC + 1);

  ctrl_state_t   state;
  logic [SW-1:0] sps_cnt;
  logic [DW-1:0] drn_cnt;
  logic [15:0]   tick_cnt;
  logic [15:0]   syms_q;
  logic          mode_q;
  logic [HB_W-1:0] hb_cnt;
  logic          btn_level;
  logic          press_i;
  logic          tick;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_deb (
    .clk  (clk),
    .rst_n(rst_n),
    .btn_n(btn_n),
    .level(btn_level),
    .press(press_i)
  );

  assign btn_press = press_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      noise_idx <= '0;
      noise_mag <= noise_lvl(3'd0, NOISE_BASE, NOISE_STEP);
    end else begin
      if (press_i && !btn_level) begin
        if (noise_idx == 3'(NUM_LVLS - 1))
          noise_idx <= '0;
        else
          noise_idx <= noise_idx + 3'd1;
      end
      noise_mag <= noise_lvl(noise_idx, NOISE_BASE, NOISE_STEP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hb_cnt <= '0;
    else
      hb_cnt <= hb_cnt + 1'b1;
  end

  assign heartbeat  = hb_cnt[HB_W-1];
  assign tick       = (state == ST_RUN) && (sps_cnt == '0);
  assign sym_tick   = tick;
  assign tx_en      = (state == ST_RUN) || (state == ST_DRAIN);
  assign burst_done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sps_cnt  <= '0;
      drn_cnt  <= '0;
      tick_cnt <= '0;
      syms_q   <= '0;
      mode_q   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start && !stop &&
              (!mode_burst || burst_syms != '0)) begin
            state    <= ST_RUN;
            sps_cnt  <= '0;
            tick_cnt <= '0;
            syms_q   <= burst_syms;
            mode_q   <= mode_burst;
          end
        end
        ST_RUN: begin
          if (sps_cnt == SW'(SPS - 1))
            sps_cnt <= '0;
          else
            sps_cnt <= sps_cnt + 1'b1;
          if (tick)
            tick_cnt <= tick_cnt + 16'd1;
          // Count is checked one cycle after the last tick lands.
          if (stop || (mode_q && tick_cnt == syms_q)) begin
            state   <= ST_DRAIN;
            drn_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          if (drn_cnt == DW'(DRAIN_CYC - 1))
            state <= ST_DONE;
          else
            drn_cnt <= drn_cnt + 1'b1;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gdsp_ctrl.sv
// Directed self-checking bench for gdsp_ctrl.
module tb_gdsp_ctrl;

  localparam int SPS   = 4;
  localparam int DEB   = 8;
  localparam int DRAIN = 5;
  localparam int LVLS  = 4;
  localparam int HBW   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_n = 1'b1;
  logic        mode_burst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] burst_syms = '0;
  logic        sym_tick, tx_en, btn_press;
  logic        burst_done, heartbeat;
  logic [7:0]  noise_mag;
  logic [2:0]  noise_idx;

  gdsp_ctrl #(
    .SPS(SPS), .DEBOUNCE_CYC(DEB), .NUM_LVLS(LVLS),
    .NOISE_BASE(32), .NOISE_STEP(32),
    .DRAIN_CYC(DRAIN), .HB_W(HBW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_n),
    .mode_burst(mode_burst), .start(start), .stop(stop),
    .burst_syms(burst_syms), .sym_tick(sym_tick),
    .tx_en(tx_en), .noise_mag(noise_mag),
    .noise_idx(noise_idx), .btn_press(btn_press),
    .burst_done(burst_done), .heartbeat(heartbeat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        sp;
    logic        md;
    logic [15:0] syms;
    logic        tick;
    logic        tx;
    logic        done;
  } vec_t;

  vec_t tbl[17];
  int total = 0;
  int bad = 0;
  int press_cnt = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (btn_press === 1'b1) press_cnt++;
    if (burst_done === 1'b1) done_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 17; i++) begin
      start      = tbl[i].st;
      stop       = tbl[i].sp;
      mode_burst = tbl[i].md;
      burst_syms = tbl[i].syms;
      step();
      chk($sformatf("%s_tick%0d", tag, i), 32'(sym_tick), 32'(tbl[i].tick));
      chk($sformatf("%s_tx%0d", tag, i), 32'(tx_en), 32'(tbl[i].tx));
      chk($sformatf("%s_done%0d", tag, i), 32'(burst_done), 32'(tbl[i].done));
    end
    start = 1'b0;
  endtask

  task automatic press_btn(input int low_cyc);
    btn_n = 1'b0;
    repeat (low_cyc) step();
    btn_n = 1'b1;
    repeat (20) step();
  endtask

  initial begin : main
    int n, d, tk, g, pc, dc;
    logic [7:0] mags [4];
    mags[0] = 8'd64; mags[1] = 8'd96;
    mags[2] = 8'd128; mags[3] = 8'd32;

    // Row i holds the outputs seen in cycle t0+i+1.
    for (int i = 0; i < 17; i++) begin
      tbl[i].st   = (i == 0);
      tbl[i].sp   = 1'b0;
      tbl[i].md   = 1'b1;
      tbl[i].syms = 16'd3;
      tbl[i].tick = (i == 0) || (i == 4) || (i == 8);
      tbl[i].tx   = (i <= 14);
      tbl[i].done = (i == 15);
    end

    repeat (3) @(negedge clk);
    chk("rst_tick", 32'(sym_tick), 0);
    chk("rst_tx", 32'(tx_en), 0);
    chk("rst_done", 32'(burst_done), 0);
    chk("rst_press", 32'(btn_press), 0);
    chk("rst_hb", 32'(heartbeat), 0);
    chk("rst_idx", 32'(noise_idx), 0);
    chk("rst_mag", 32'(noise_mag), 32);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) step();
    chk("hb_7", 32'(heartbeat), 0);
    step();
    chk("hb_8", 32'(heartbeat), 1);

    run_table("burst");

    // Short glitch must not be accepted.
    press_btn(5);
    chk("glitch_press", 32'(press_cnt), 0);
    chk("glitch_idx", 32'(noise_idx), 0);
    for (int p = 0; p < 4; p++) begin
      pc = press_cnt;
      press_btn(20);
      chk($sformatf("press%0d_cnt", p), 32'(press_cnt - pc), 1);
      chk($sformatf("press%0d_idx", p), 32'(noise_idx), 32'((p + 1) % LVLS));
      chk($sformatf("press%0d_mag", p), 32'(noise_mag), 32'(mags[p]));
    end

    // Continuous run with a mode flip mid-run.
    mode_burst = 1'b0;
    burst_syms = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("cont_first_tick", 32'(sym_tick), 1);
    n = sym_tick ? 1 : 0;
    g = 0;
    while (n < 10 && g < 200) begin
      if (n >= 3) begin
        mode_burst = 1'b1;
        burst_syms = 16'd2;
      end
      step();
      if (sym_tick) n++;
      g++;
    end
    chk("cont_ticks", 32'(n), 10);
    stop = 1'b1;
    step();
    stop = 1'b0;
    d = 0; tk = 0; g = 0;
    while (burst_done !== 1'b1 && g < 50) begin
      if (tx_en) d++;
      if (sym_tick) tk++;
      step();
      g++;
    end
    chk("cont_drain_len", 32'(d), 5);
    chk("cont_drain_ticks", 32'(tk), 0);
    chk("cont_done", 32'(burst_done), 1);
    step();
    chk("cont_idle_tx", 32'(tx_en), 0);
    chk("cont_idle_done", 32'(burst_done), 0);

    // Zero-length burst is ignored.
    dc = done_cnt;
    mode_burst = 1'b1;
    burst_syms = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("zero_tx", 32'(tx_en), 0);
    repeat (5) step();
    chk("zero_tx_late", 32'(tx_en), 0);
    chk("zero_no_done", 32'(done_cnt - dc), 0);

    // Stop wins over start.
    mode_burst = 1'b0;
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    chk("ss_tx", 32'(tx_en), 0);
    step();
    chk("ss_tx2", 32'(tx_en), 0);

    // Start during DRAIN is ignored.
    mode_burst = 1'b1;
    burst_syms = 16'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("dr_t1_tick", 32'(sym_tick), 1);
    step();
    step();
    chk("dr_t3_tx", 32'(tx_en), 1);
    chk("dr_t3_tick", 32'(sym_tick), 0);
    step();
    burst_syms = 16'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("dr_t5_tx", 32'(tx_en), 1);
    chk("dr_t5_tick", 32'(sym_tick), 0);
    step();
    step();
    chk("dr_t7_done", 32'(burst_done), 0);
    step();
    chk("dr_t8_done", 32'(burst_done), 1);
    step();
    chk("dr_t9_tx", 32'(tx_en), 0);
    step();
    chk("dr_t10_tx", 32'(tx_en), 0);

    // Reset in the middle of a run.
    press_btn(20);
    chk("pre_rst_idx", 32'(noise_idx), 1);
    mode_burst = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    chk("pre_rst_tx", 32'(tx_en), 1);
    dc = done_cnt;
    rst_n = 1'b0;
    #2;
    chk("mid_rst_tick", 32'(sym_tick), 0);
    chk("mid_rst_tx", 32'(tx_en), 0);
    chk("mid_rst_done", 32'(burst_done), 0);
    chk("mid_rst_press", 32'(btn_press), 0);
    chk("mid_rst_hb", 32'(heartbeat), 0);
    chk("mid_rst_idx", 32'(noise_idx), 0);
    chk("mid_rst_mag", 32'(noise_mag), 32);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_tx", 32'(tx_en), 0);
    chk("post_rst_nodone", 32'(done_cnt - dc), 0);

    run_table("burst2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
